// File: rtl/e_muldiv_pkg.sv
// Shared constants for the E-stage multiply/divide unit: md_op encodings,
// default latencies and the types used by e_muldiv.
package e_muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  // Wide enough for any practical latency (both latencies must be 1..255).
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/e_muldiv.sv
// Multi-cycle multiply/divide unit beside the E-stage ALU. Owns HI/LO,
// computes the result at start, and commits it after a fixed busy window.
module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [3:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] result
);

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  hilo_t            hilo;
  hilo_t            pend;
  logic             pend_wr;

  hilo_t            arith_res;
  logic             arith_wr;
  logic             accept;
  logic             accept_arith;
  logic             last;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic               div_ovf;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  // Starts are only honoured in IDLE; anything issued while busy is dropped.
  assign accept       = (state == ST_IDLE) && start;
  assign accept_arith = accept && is_arith(md_op);
  assign last         = (state == ST_RUN) && (cnt == CNT_W'(1));

  // ---------------------------------------------------------------------
  // Arithmetic, evaluated on the operands present in the start cycle
  // ---------------------------------------------------------------------
  assign prod_s  = $signed({{32{data1[31]}}, data1}) * $signed({{32{data2[31]}}, data2});
  assign prod_u  = {32'd0, data1} * {32'd0, data2};
  // A zero divisor is swapped for 1 to keep the dividers free of X; the
  // result is never committed in that case.
  assign div_b   = (data2 == 32'd0) ? 32'd1 : data2;
  assign div_ovf = (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);
  assign quo_u   = data1 / div_b;
  assign rem_u   = data1 % div_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    quo_s = 32'sd0;
    rem_s = 32'sd0;
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
      rem_s = 32'sd0;
    end else begin
      quo_s = $signed(data1) / $signed(div_b);
      rem_s = $signed(data1) % $signed(div_b);
    end
  end

  always_comb begin
    arith_res = '0;
    arith_wr  = 1'b0;
    case (md_op)
      MD_MULT: begin
        arith_res = hilo_t'(prod_s);
        arith_wr  = 1'b1;
      end
      MD_MULTU: begin
        arith_res = hilo_t'(prod_u);
        arith_wr  = 1'b1;
      end
      MD_DIV: begin
        arith_res.hi = rem_s;
        arith_res.lo = quo_s;
        arith_wr     = (data2 != 32'd0);
      end
      MD_DIVU: begin
        arith_res.hi = rem_u;
        arith_res.lo = quo_u;
        arith_wr     = (data2 != 32'd0);
      end
      default: begin
        arith_res = '0;
        arith_wr  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples the pre-edge values of its peers.
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_arith) state_nxt = ST_RUN;
      ST_RUN:  if (last)         state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // ---------------------------------------------------------------------
  // Counter, pending result and HI/LO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: HI/LO and the pending result are architectural state visible
    // through mfhi/mflo, so they are cleared by reset along with the counter.
    if (!reset) begin
      cnt     <= '0;
      hilo    <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (accept_arith) begin
      cnt     <= is_mul(md_op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
      pend    <= arith_res;
      pend_wr <= arith_wr;
    end else if (accept) begin
      if (md_op == MD_MTHI) hilo.hi <= data1;
      if (md_op == MD_MTLO) hilo.lo <= data1;
    end else if (state == ST_RUN) begin
      cnt <= cnt - 1'b1;
      if (last && pend_wr) hilo <= pend;
    end
  end

  // mfhi/mflo read committed HI/LO only; the stall unit holds them while busy.
  always_comb begin
    result = 32'd0;
    case (md_op)
      MD_MFHI: result = hilo.hi;
      MD_MFLO: result = hilo.lo;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_muldiv.sv
// Scoreboard bench for e_muldiv: stimulus pushes expected reads and busy
// lengths, a negedge monitor pops and compares them.
module tb_e_muldiv;
  import e_muldiv_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data1 = 32'd0;
  logic [31:0] data2 = 32'd0;
  logic [3:0]  md_op = MD_NONE;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] result;

  always #5 clk = ~clk;

  e_muldiv #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .data1 (data1),
    .data2 (data2),
    .md_op (md_op),
    .start (start),
    .busy  (busy),
    .result(result)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          illegal_starts = 0;
  int          busy_cnt = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: HI/LO as the architecture defines them, in 64-bit math.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    case (op)
      MD_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        p = sa * sb;
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MD_MULTU: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        p = ua * ub;
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MD_DIV: if (b != 32'd0) begin
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      MD_DIVU: if (b != 32'd0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      MD_MTHI: hi_m = a;
      MD_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Monitor: busy window lengths and mfhi/mflo reads.
  always @(negedge clk) begin
    rd_exp_t r;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (start && busy) illegal_starts++;
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (lat_q.size() == 0) check("busy_unexpected", 32'(busy_cnt), 32'd0);
        else                   check("busy_len", 32'(busy_cnt), 32'(lat_q.pop_front()));
        busy_cnt = 0;
      end
      if (md_op == MD_MFHI || md_op == MD_MFLO) begin
        if (rd_q.size() == 0) begin
          check("read_unexpected", result, 32'hDEAD_BEEF);
        end else begin
          r = rd_q.pop_front();
          check(r.name, result, r.val);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit aborted = 1'b0);
    data1 = a;
    data2 = b;
    md_op = op;
    start = 1'b1;
    if (!aborted) begin
      model(op, a, b);
      if (op == MD_MULT || op == MD_MULTU)    lat_q.push_back(MUL_LAT);
      else if (op == MD_DIV || op == MD_DIVU) lat_q.push_back(DIV_LAT);
    end
    @(posedge clk); #1;
    start = 1'b0;
    md_op = MD_NONE;
    data1 = $urandom;
    data2 = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_hilo();
    md_op = MD_MFHI;
    rd_q.push_back('{name: "mfhi", val: hi_m});
    @(posedge clk); #1;
    md_op = MD_MFLO;
    rd_q.push_back('{name: "mflo", val: lo_m});
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_idle();
    read_hilo();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    md_op = MD_MFHI; #1;
    check("reset_hi", result, 32'd0);
    md_op = MD_MFLO; #1;
    check("reset_lo", result, 32'd0);
    md_op = MD_NONE;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed operations
    run_op(MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_op(MD_DIVU,  32'd7,         32'd2);

    // MTHI/MTLO, immediate readback, then divide by zero keeps HI/LO
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    read_hilo();
    issue(MD_MTLO, 32'h0000_5678, 32'd0);
    read_hilo();
    run_op(MD_DIVU, 32'h0BAD_F00D, 32'd0);
    run_op(MD_DIV,  32'h0BAD_F00D, 32'd0);

    // Signed overflow case
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start while busy is ignored
    issue(MD_MULT, 32'd1000, 32'hFFFF_FFFD);
    repeat (2) begin @(posedge clk); #1; end
    data1 = 32'd77; data2 = 32'd5; md_op = MD_DIV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    wait_idle();
    read_hilo();

    // Back-to-back: reissue in the first busy=0 cycle
    issue(MD_MULT, 32'd123, 32'd456);
    wait_idle();
    issue(MD_DIVU, 32'd1000, 32'd7);
    wait_idle();
    read_hilo();

    // Reset mid-run at busy cycle 3
    issue(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    md_op = MD_MFHI; #1;
    check("midreset_hi", result, 32'd0);
    md_op = MD_MFLO; #1;
    check("midreset_lo", result, 32'd0);
    md_op = MD_NONE;
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    #1 reset = 1'b1;
    run_op(MD_MULTU, 32'd3, 32'd4);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 5))
        0:       op = MD_MULT;
        1:       op = MD_MULTU;
        2:       op = MD_DIV;
        3:       op = MD_DIVU;
        4:       op = MD_MTHI;
        default: op = MD_MTLO;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(op, a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reads_pending", 32'(rd_q.size()), 32'd0);
    check("busy_windows_pending", 32'(lat_q.size()), 32'd0);
    check("illegal_starts", 32'(illegal_starts), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/e_muldiv.md
# e_muldiv

Multi-cycle multiply/divide unit in the E stage of the five-stage MIPS pipeline, beside the single-cycle ALU. It accepts rs/rt operands with a start pulse and computes products and quotients over a fixed latency, owning the HI/LO registers. It returns HI/LO to the pipeline for mfhi/mflo and raises busy so the stall unit can hold dependent instructions in D.

## Interface

Parameters:
- MUL_LAT, default 5: cycles busy stays high for mult/multu.
- DIV_LAT, default 10: cycles busy stays high for div/divu.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state.
- data1  input  32  rs operand, valid when start=1.
- data2  input  32  rt operand, valid when start=1.
- md_op  input  4  operation code from the shared constants (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO).
- start  input  1  one-cycle strobe; qualifies md_op for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- busy  output  1  operation in flight; reset value 0.
- result  output  32  combinational read: HI when md_op=MFHI, LO when md_op=MFLO, else 0; reset value 0 (HI=LO=0).

## Operation

- Two states: IDLE, RUN. Down-counter cnt holds the remaining cycles; pending hi_n/lo_n hold the computed result.
- IDLE, start=1, md_op in MULT/MULTU/DIV/DIVU: capture result into hi_n/lo_n, load cnt with MUL_LAT or DIV_LAT, go to RUN, busy=1 from the next edge.
- RUN: decrement cnt each cycle. When cnt reaches 1, commit hi_n/lo_n to HI/LO, clear busy, return to IDLE on that edge.
- MULT: {HI,LO} = signed 32x32 -> 64 product. MULTU: unsigned product.
- DIV: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign. DIVU: unsigned quotient/remainder.
- 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
- Divide by zero (data2=0, DIV or DIVU): busy runs the full DIV_LAT, and HI/LO keep their prior values.
- MTHI/MTLO with start=1 in IDLE: write data1 to HI/LO on that edge. busy is not asserted.
- Any start while busy=1 is ignored. The stall unit must never issue one; the bench flags it as an assertion.
- MFHI/MFLO read committed HI/LO only. The stall unit stalls them while start|busy.

## Timing

- Start sampled at edge E0.
- busy is high for exactly MUL_LAT (or DIV_LAT) cycles after E0.
- HI/LO update on the same edge busy falls, so they are readable in the first cycle busy=0.
- Back-to-back: start may be reissued in the first cycle busy=0.
- MTHI/MTLO: HI/LO are visible to result the cycle after the start edge.
- Reset asserted at any time, including mid-RUN: immediately busy=0, state=IDLE, cnt=0, HI=LO=0, pending result discarded. The first start is accepted on the first edge after release.
- Stall-unit rule (outside this block): stall D when the D instruction is an md op and (start in E or busy).

## Structure

- md_op encodings belong in the shared constants package, next to the ALU control codes: NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- MUL_LAT/DIV_LAT defaults also live in the shared constants.
- No sub-module: one sequential block (state, counter, HI/LO, pending registers) plus a combinational arithmetic/read mux.

## Test plan

- MULT 0xFFFFFFFF x 0x00000002 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 -> busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- Set HI=0x1234, LO=0x5678 via MTHI/MTLO. Then DIVU x/0 -> busy 10 cycles; MFHI=0x1234, MFLO=0x5678. MFHI read the cycle after MTHI returns the new value.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT started, reset pulsed low at cycle 3 -> busy=0 immediately, HI=LO=0. A new MULTU 3x4 after release -> LO=12, HI=0 after 5 cycles.
- Start MULT, then a second start during busy -> second start ignored, HI/LO reflect the first op only. Start reissued in the first busy=0 cycle -> accepted.
